// File: rtl/mem_addr_seq_if.sv
// mem_addr_seq_if: request, beat and status signals of the load/store address sequencer.
interface mem_addr_seq_if #(
    parameter int ADDR_W = 32,
    parameter int NREGS  = 16
);
    logic                       start;
    logic [1:0]                 mode;
    logic                       dir;
    logic [ADDR_W-1:0]          rn;
    logic [ADDR_W-1:0]          rm;
    logic [ADDR_W-1:0]          imm32;
    logic [ADDR_W-1:0]          pc_real;
    logic [NREGS-1:0]           reg_list;
    logic                       mem_ready;
    logic                       busy;
    logic                       mem_req;
    logic [ADDR_W-1:0]          mem_addr;
    logic [$clog2(NREGS)-1:0]   reg_idx;
    logic                       last;
    logic                       done;
    logic                       err_empty;
    logic [ADDR_W-1:0]          wb_addr;
    modport master (
        output start, mode, dir, rn, rm, imm32, pc_real, reg_list, mem_ready,
        input  busy, mem_req, mem_addr, reg_idx, last, done, err_empty, wb_addr
    );
    modport slave (
        input  start, mode, dir, rn, rm, imm32, pc_real, reg_list, mem_ready,
        output busy, mem_req, mem_addr, reg_idx, last, done, err_empty, wb_addr
    );
endinterface

// File: rtl/mem_addr_seq.sv
// mem_addr_seq: single-transfer and LDM/STM/PUSH/POP address sequencer with ready handshake.
module mem_addr_seq #(
    parameter int ADDR_W = 32,
    parameter int NREGS  = 16,
    parameter int STEP   = 4
) (
    input logic           clk,
    input logic           rst_n,
    mem_addr_seq_if.slave bus
);
    localparam int IDX_W = $clog2(NREGS);
    typedef enum logic [1:0] {IDLE, SINGLE, MULTI} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, wb_q, wb_d, base, span, single_addr;
    logic [NREGS-1:0]  list_q, list_d, list_rest;
    logic              done_q, done_d, err_q, err_d, accept;
    function automatic logic [ADDR_W-1:0] popcnt(input logic [NREGS-1:0] v);
        popcnt = '0;
        for (int i = 0; i < NREGS; i++) popcnt = popcnt + ADDR_W'(v[i]);
    endfunction
    function automatic logic [IDX_W-1:0] lowest(input logic [NREGS-1:0] v);
        lowest = '0;
        for (int i = NREGS - 1; i >= 0; i--) if (v[i]) lowest = IDX_W'(i);
    endfunction
    assign base        = {bus.rn[ADDR_W-1:2], 2'b00};
    assign span        = ADDR_W'(STEP) * popcnt(bus.reg_list);
    assign single_addr = bus.mode == 2'd0 ? bus.rn + bus.rm :
                         bus.mode == 2'd1 ? bus.rn + bus.imm32 :
                         {bus.pc_real[ADDR_W-1:2], 2'b00} + bus.imm32;
    assign list_rest   = list_q & (list_q - NREGS'(1));
    assign accept      = bus.mem_req & bus.mem_ready;
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        list_d  = list_q;
        wb_d    = wb_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                if (bus.mode != 2'd3) begin
                    state_d = SINGLE;
                    addr_d  = single_addr;
                    wb_d    = single_addr;
                    list_d  = '0;
                end else if (bus.reg_list == '0) begin
                    err_d  = 1'b1;
                    done_d = 1'b1;
                end else begin
                    state_d = MULTI;
                    list_d  = bus.reg_list;
                    addr_d  = bus.dir ? base - span : base;
                    wb_d    = bus.dir ? base - span : base + span;
                end
            end
            SINGLE: if (accept) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            MULTI: if (accept) begin
                // Lowest register always takes the lowest address, so both directions walk upward.
                if (list_rest == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    list_d = list_rest;
                    addr_d = addr_q + ADDR_W'(STEP);
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            list_q  <= '0;
            wb_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            list_q  <= list_d;
            wb_q    <= wb_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
    assign bus.busy      = state_q != IDLE;
    assign bus.mem_req   = state_q != IDLE;
    assign bus.mem_addr  = addr_q;
    assign bus.reg_idx   = state_q == MULTI ? lowest(list_q) : '0;
    assign bus.last      = state_q == SINGLE || (state_q == MULTI && list_rest == '0);
    assign bus.done      = done_q;
    assign bus.err_empty = err_q;
    assign bus.wb_addr   = wb_q;
endmodule

// File: tb/tb_mem_addr_seq.sv
// tb_mem_addr_seq: directed scenario tasks for mem_addr_seq with hand-computed expectations.
module tb_mem_addr_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    mem_addr_seq_if #(.ADDR_W(32), .NREGS(16)) bus ();
    mem_addr_seq #(.ADDR_W(32), .NREGS(16), .STEP(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic go(input logic [1:0] m, input logic d, input logic [31:0] r_n, r_m, im, pc,
                      input logic [15:0] rl);
        bus.start = 1'b1; bus.mode = m; bus.dir = d; bus.rn = r_n; bus.rm = r_m;
        bus.imm32 = im; bus.pc_real = pc; bus.reg_list = rl;
        step();
        bus.start = 1'b0;
    endtask
    task automatic test_reset;
        #2;
        total++;
        if ({bus.busy, bus.mem_req, bus.mem_addr, bus.reg_idx, bus.last, bus.done, bus.err_empty, bus.wb_addr} !== 73'd0) begin
            bad++; $display("FAIL reset_init busy=%b req=%b addr=%h done=%b wb=%h want all 0", bus.busy, bus.mem_req, bus.mem_addr, bus.done, bus.wb_addr);
        end
        step();
        rst_n = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        go(2'd3, 1'b0, 32'h300, 32'h0, 32'h0, 32'h0, 16'h00F0);
        total++;
        if ({bus.busy, bus.mem_addr, bus.reg_idx} !== {1'b1, 32'h300, 4'd4}) begin
            bad++; $display("FAIL reset_pre busy=%b addr=%h idx=%0d want 1 300 4", bus.busy, bus.mem_addr, bus.reg_idx);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.mem_req, bus.mem_addr, bus.reg_idx, bus.last, bus.done, bus.err_empty, bus.wb_addr} !== 73'd0) begin
            bad++; $display("FAIL reset_async busy=%b req=%b addr=%h idx=%0d wb=%h want all 0", bus.busy, bus.mem_req, bus.mem_addr, bus.reg_idx, bus.wb_addr);
        end
        step();
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({bus.busy, bus.done} !== 2'b00) begin
                bad++; $display("FAIL reset_release cyc=%0d busy=%b done=%b want 0 0", i, bus.busy, bus.done);
            end
        end
    endtask
    task automatic test_single_imm;
        bus.mem_ready = 1'b1;
        go(2'd1, 1'b0, 32'h2000_0000, 32'h0, 32'h10, 32'h0, 16'h0);
        total++;
        if ({bus.busy, bus.mem_req, bus.mem_addr, bus.reg_idx, bus.last} !== {2'b11, 32'h2000_0010, 4'd0, 1'b1}) begin
            bad++; $display("FAIL single_beat addr=%h idx=%0d last=%b want 20000010 0 1", bus.mem_addr, bus.reg_idx, bus.last);
        end
        step();
        total++;
        if ({bus.done, bus.busy, bus.mem_req} !== 3'b100) begin
            bad++; $display("FAIL single_done done=%b busy=%b req=%b want 1 0 0", bus.done, bus.busy, bus.mem_req);
        end
        step();
        total++;
        if (bus.done !== 1'b0) begin
            bad++; $display("FAIL single_pulse done=%b want 0", bus.done);
        end
    endtask
    task automatic test_back_to_back;
        go(2'd0, 1'b0, 32'h1000, 32'h234, 32'h0, 32'h0, 16'h0);
        total++;
        if ({bus.mem_addr, bus.last} !== {32'h1234, 1'b1}) begin
            bad++; $display("FAIL rn_rm addr=%h last=%b want 1234 1", bus.mem_addr, bus.last);
        end
        step();
        total++;
        if (bus.done !== 1'b1) begin
            bad++; $display("FAIL b2b_done done=%b want 1", bus.done);
        end
        go(2'd2, 1'b0, 32'h0, 32'h0, 32'h20, 32'h0000_0106, 16'h0);
        total++;
        if ({bus.busy, bus.mem_req, bus.mem_addr, bus.last} !== {2'b11, 32'h124, 1'b1}) begin
            bad++; $display("FAIL pc_align busy=%b addr=%h last=%b want 1 124 1", bus.busy, bus.mem_addr, bus.last);
        end
        step();
        total++;
        if ({bus.done, bus.busy} !== 2'b10) begin
            bad++; $display("FAIL pc_done done=%b busy=%b want 1 0", bus.done, bus.busy);
        end
    endtask
    task automatic test_multi_inc;
        logic [31:0] ea [3] = '{32'h100, 32'h104, 32'h108};
        logic [3:0]  ei [3] = '{4'd1, 4'd2, 4'd4};
        bus.mem_ready = 1'b1;
        go(2'd3, 1'b0, 32'h102, 32'h0, 32'h0, 32'h0, 16'h0016);
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({bus.busy, bus.mem_req, bus.mem_addr, bus.reg_idx, bus.last, bus.wb_addr} !== {2'b11, ea[i], ei[i], i == 2, 32'h10C}) begin
                bad++; $display("FAIL inc_beat%0d addr=%h idx=%0d last=%b wb=%h want %h %0d %b 10c", i, bus.mem_addr, bus.reg_idx, bus.last, bus.wb_addr, ea[i], ei[i], i == 2);
            end
            step();
        end
        total++;
        if ({bus.done, bus.busy, bus.mem_req} !== 3'b100) begin
            bad++; $display("FAIL inc_done done=%b busy=%b req=%b want 1 0 0", bus.done, bus.busy, bus.mem_req);
        end
    endtask
    task automatic test_multi_dec_stall;
        logic [31:0] ea [3] = '{32'h1F4, 32'h1F8, 32'h1FC};
        logic [3:0]  ei [3] = '{4'd0, 4'd4, 4'd14};
        bus.mem_ready = 1'b0;
        go(2'd3, 1'b1, 32'h200, 32'h0, 32'h0, 32'h0, 16'h4011);
        for (int i = 0; i < 3; i++) begin
            for (int s = 0; s < 2; s++) begin
                total++;
                if ({bus.busy, bus.mem_req, bus.mem_addr, bus.reg_idx, bus.last, bus.wb_addr, bus.done} !== {2'b11, ea[i], ei[i], i == 2, 32'h1F4, 1'b0}) begin
                    bad++; $display("FAIL dec_beat%0d_%0d addr=%h idx=%0d last=%b wb=%h done=%b want %h %0d %b 1f4 0", i, s, bus.mem_addr, bus.reg_idx, bus.last, bus.wb_addr, bus.done, ea[i], ei[i], i == 2);
                end
                bus.start = 1'b1;
                step();
                bus.start = 1'b0;
                bus.mem_ready = ~bus.mem_ready;
            end
        end
        total++;
        if ({bus.done, bus.busy} !== 2'b10) begin
            bad++; $display("FAIL dec_done done=%b busy=%b want 1 0", bus.done, bus.busy);
        end
    endtask
    task automatic test_empty;
        bus.mem_ready = 1'b1;
        go(2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 16'h0);
        total++;
        if ({bus.err_empty, bus.done, bus.busy, bus.mem_req} !== 4'b1100) begin
            bad++; $display("FAIL empty err=%b done=%b busy=%b req=%b want 1 1 0 0", bus.err_empty, bus.done, bus.busy, bus.mem_req);
        end
        step();
        total++;
        if ({bus.err_empty, bus.done, bus.busy, bus.mem_req} !== 4'b0000) begin
            bad++; $display("FAIL empty_pulse err=%b done=%b busy=%b req=%b want 0 0 0 0", bus.err_empty, bus.done, bus.busy, bus.mem_req);
        end
    endtask
    task automatic test_wrap_busy_ignore;
        logic [31:0] ea [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
        bus.mem_ready = 1'b1;
        go(2'd3, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h0, 32'h0, 16'h0007);
        bus.start = 1'b1; bus.mode = 2'd1; bus.rn = 32'h0; bus.imm32 = 32'h40;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus.start = 1'b0;
            total++;
            if ({bus.mem_req, bus.mem_addr, bus.reg_idx, bus.last, bus.wb_addr} !== {1'b1, ea[i], 4'(i), i == 2, 32'h4}) begin
                bad++; $display("FAIL wrap_beat%0d addr=%h idx=%0d last=%b wb=%h want %h %0d %b 4", i, bus.mem_addr, bus.reg_idx, bus.last, bus.wb_addr, ea[i], i, i == 2);
            end
            step();
        end
        total++;
        if ({bus.done, bus.busy} !== 2'b10) begin
            bad++; $display("FAIL wrap_done done=%b busy=%b want 1 0", bus.done, bus.busy);
        end
        step();
        total++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            bad++; $display("FAIL wrap_idle done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
    endtask
    initial begin
        bus.start = 1'b0; bus.mode = 2'd0; bus.dir = 1'b0; bus.rn = '0; bus.rm = '0;
        bus.imm32 = '0; bus.pc_real = '0; bus.reg_list = '0; bus.mem_ready = 1'b0;
        test_reset();
        test_single_imm();
        test_back_to_back();
        test_multi_inc();
        test_multi_dec_stall();
        test_empty();
        test_wrap_busy_ignore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
